sub_bytes_pipe: RTL
===================

Name: sub_bytes_pipe

Overview:
Parametrised, pipelined AES SubBytes engine. It substitutes LANES bytes per transaction through the forward or inverse AES S-box, with the mode selected per transaction. Valid/ready handshakes on both sides with full backpressure, so it sits between the round-key-add stage and ShiftRows in both the encrypt and decrypt datapaths. Throughput is one transaction per clock when unstalled.

Parameters:
LANES, 16, number of byte lanes per transaction (1..16; 16 = full 128-bit state)
PIPE_STAGES, 2, register stages from input to output (1..4); equals latency in cycles
INV_EN, 1, 1 = inverse S-box tables instantiated; 0 = forward only, in_mode ignored
TAG_W, 4, width of the sideband tag carried alongside the data (round number or context id)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept a transaction this cycle
in_mode  in  1  0 = forward S-box (encrypt), 1 = inverse S-box (decrypt)
in_data  in  8*LANES  lane i = in_data[8i+7:8i]
in_tag  in  TAG_W  sideband, passed through unchanged
out_valid  out  1  output transaction valid
out_ready  in  1  downstream accepts
out_data  out  8*LANES  substituted bytes, same lane order as input
out_mode  out  1  mode actually applied (forced 0 when INV_EN=0)
out_tag  out  TAG_W  tag of this transaction
busy  out  1  OR of all stage valid bits

Behaviour:
- Reset (rst_n=0 sampled at a clk edge): all stage valid bits clear; out_valid=0, busy=0, out_data=0, out_mode=0, out_tag=0. in_ready=0 while rst_n=0 and 1 from the first cycle after reset release. Reset mid-operation discards every in-flight transaction; nothing is emitted afterwards.
- Handshake: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready. in_valid is not required to wait for in_ready.
- Lookup: combinational per lane, between the input port and the stage-1 register. Stages 2..PIPE_STAGES are delay stages that carry data, mode and tag.
- Stage k advances when its successor is empty or advancing; the last stage advances on out_ready. in_ready = !v[1] || stage 1 advancing (same-cycle pass-through of the stall chain; no combinational path from in_valid to in_ready).
- Latency: a transaction accepted at edge N has out_valid=1 after edge N+PIPE_STAGES, provided there is no stall.
- Stall: while out_valid && !out_ready, out_data/out_mode/out_tag hold stable. Bubbles in front of a stall are collapsed. With all stages full and out_ready=0, in_ready=0.
- Simultaneous accept and consume with the pipe full: both occur in the same cycle and no bubble is inserted.
- Mode is per transaction. Alternating fwd/inv on consecutive cycles must work without a gap.
- INV_EN=0: in_mode ignored, forward table used, out_mode=0. The inverse table is not synthesised.
- Ordering is strictly FIFO. No transaction is dropped or duplicated.
- Data and tag registers use no reset beyond the reset values listed above; valid bits are always reset.

Decomposition:
- Shared package aes_pkg: SBOX[256] and INV_SBOX[256] byte constant arrays (FIPS-197), mode constants MODE_FWD=0 / MODE_INV=1, byte type.
- One sub-module: aes_sbox_lane. Combinational byte in, mode in, byte out; INV_EN parameter. Instantiated LANES times in a generate loop.
- sub_bytes_pipe holds only the stage registers and handshake control.

Test Plan:
- Single-byte vectors (LANES=1, mode 0): 0x00->0x63, 0x53->0xED, 0xFF->0x16. Mode 1: 0x63->0x00, 0xED->0x53, 0x16->0xFF. Each out_valid exactly PIPE_STAGES cycles after accept.
- Full state (LANES=16, mode 0): in_data lanes 0..15 = 0x00..0x0F -> lanes 63 7C 77 7B F2 6B 6F C5 30 01 67 2B FE D7 AB 76. Same data in mode 1 -> lanes 52 09 6A D5 30 36 A5 38 BF 40 A3 9E 81 F3 D7 FB.
- Exhaustive round trip: all 256 bytes forward, then the results inverse back-to-back with alternating tags. Every byte returns to its original value, tags match, one result per cycle.
- Backpressure: stream 8 transactions with out_ready=0 for 5 cycles. in_ready drops after PIPE_STAGES accepts, outputs hold stable, and after release all 8 arrive in order with no loss or duplicates. Also run a random out_ready toggle at 50%.
- Reset mid-stream: assert rst_n=0 for 1 cycle with the pipe full. The next cycle shows out_valid=0, busy=0, in_ready=0; one cycle later in_ready=1 and no stale data is ever emitted.
- INV_EN=0 build: in_mode=1 with in_data byte 0x63 -> 0xFB (forward table), out_mode=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants: forward/inverse S-box tables (FIPS-197), mode encodings.
package aes_pkg;

    typedef logic [7:0] byte_t;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_sbox_lane.sv
// One byte lane of SubBytes: combinational forward/inverse S-box lookup.
module aes_sbox_lane
    import aes_pkg::*;
#(
    parameter int unsigned INV_EN = 1
) (
    input  logic [7:0] in_byte,
    input  logic       mode,
    output logic [7:0] out_byte
);

    if (INV_EN != 0) begin : g_inv
        // Table select by per-transaction mode.
        always_comb begin
            out_byte = (mode == MODE_INV) ? INV_SBOX[in_byte] : SBOX[in_byte];
        end
    end else begin : g_fwd
        logic unused_mode;
        assign unused_mode = mode;

        // Forward-only build: the inverse table is never referenced.
        always_comb begin
            out_byte = SBOX[in_byte];
        end
    end

endmodule

// File: rtl/sub_bytes_pipe.sv
// Pipelined SubBytes engine: lookup in front of stage 0, then PIPE_STAGES
// elastic register stages with valid/ready backpressure and bubble collapse.
module sub_bytes_pipe
    import aes_pkg::*;
#(
    parameter int unsigned LANES       = 16,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned INV_EN      = 1,
    parameter int unsigned TAG_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_mode,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    localparam int unsigned DW   = 8 * LANES;
    localparam int unsigned LAST = PIPE_STAGES - 1;

    logic [DW-1:0]                       sub_data;
    logic                                eff_mode;
    logic                                accept;
    logic [PIPE_STAGES-1:0]              stage_rdy;
    logic [PIPE_STAGES-1:0]              v_q, v_d;
    logic [PIPE_STAGES-1:0][DW-1:0]      data_q, data_d;
    logic [PIPE_STAGES-1:0]              mode_q, mode_d;
    logic [PIPE_STAGES-1:0][TAG_W-1:0]   tag_q, tag_d;
    logic                                rst_done_q, rst_done_d;

    assign eff_mode = (INV_EN != 0) ? in_mode : MODE_FWD;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_sbox_lane #(
            .INV_EN (INV_EN)
        ) u_lane (
            .in_byte  (in_data[8*i +: 8]),
            .mode     (eff_mode),
            .out_byte (sub_data[8*i +: 8])
        );
    end

    // Ready chain from the output back: a stage can load if empty or its successor loads.
    always_comb begin : ready_chain
        logic rdy;
        rdy       = out_ready;
        stage_rdy = '0;
        for (int unsigned j = 0; j < PIPE_STAGES; j++) begin
            rdy                  = !v_q[LAST - j] || rdy;
            stage_rdy[LAST - j] = rdy;
        end
    end

    assign rst_done_d = 1'b1;
    assign in_ready   = rst_n && rst_done_q && stage_rdy[0];
    assign accept     = in_valid && in_ready;

    // Stage advance: each ready stage takes its predecessor's contents (or the lookup result).
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        mode_d = mode_q;
        tag_d  = tag_q;
        if (stage_rdy[0]) begin
            v_d[0] = accept;
            if (accept) begin
                data_d[0] = sub_data;
                mode_d[0] = eff_mode;
                tag_d[0]  = in_tag;
            end
        end
        for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
            if (stage_rdy[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                    mode_d[k] = mode_q[k-1];
                    tag_d[k]  = tag_q[k-1];
                end
            end
        end
    end

    // Stage registers; only valid bits and the output stage payload are reset
    // (the later non-blocking writes override the bulk payload update).
    always_ff @(posedge clk) begin
        data_q <= data_d;
        mode_q <= mode_d;
        tag_q  <= tag_d;
        if (!rst_n) begin
            v_q          <= '0;
            rst_done_q   <= 1'b0;
            data_q[LAST] <= '0;
            mode_q[LAST] <= MODE_FWD;
            tag_q[LAST]  <= '0;
        end else begin
            v_q        <= v_d;
            rst_done_q <= rst_done_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign out_data  = data_q[LAST];
    assign out_mode  = mode_q[LAST];
    assign out_tag   = tag_q[LAST];
    assign busy      = |v_q;

endmodule
